// File: rtl/cell3_vector_checker.sv
// Sweeps all eight A1/A2/A3 combinations into a 3-input cell, samples ZN after a
// programmable settle time and scores it against a truth-table mask.
module cell3_vector_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [7:0]  EXPECT_MASK   = 8'h7F
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       ZN,
    output logic       A1,
    output logic       A2,
    output logic       A3,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_vec,
    output logic [2:0] vec_idx
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [2:0] r_vec;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [3:0] r_err;
    logic [7:0] r_fail;

    logic       w_mismatch;
    logic [3:0] w_err_next;

    // X/Z on ZN must score as a failure, hence the case inequality
    always_comb begin
        w_mismatch = (ZN !== EXPECT_MASK[r_vec]);
        w_err_next = r_err + {3'b000, w_mismatch};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_vec   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_fail  <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state <= SETTLE;
                        r_cnt   <= '0;
                        r_vec   <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                        r_err   <= '0;
                        r_fail  <= '0;
                    end
                end
                SETTLE: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    r_err         <= w_err_next;
                    r_fail[r_vec] <= r_fail[r_vec] | w_mismatch;
                    if (r_vec == 3'd7) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == 4'd0);
                    end else begin
                        r_state <= SETTLE;
                        r_vec   <= r_vec + 3'd1;
                        r_cnt   <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // The applied vector and the reported index are the same register
    assign {A1, A2, A3} = r_vec;
    assign vec_idx      = r_vec;
    assign busy         = r_busy;
    assign done         = r_done;
    assign pass         = r_pass;
    assign err_count    = r_err;
    assign fail_vec     = r_fail;

endmodule

// File: tb/tb_cell3_vector_checker.sv
// Bench for cell3_vector_checker: two instances (default and SETTLE=1/NOR3 mask)
// driven by truth-table cell models, scored against expected sweep results.
module tb_cell3_vector_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, rst1, start0, start1;
    logic [7:0] tt0, tt1;
    logic       zn0, zn1;
    logic       a1_0, a2_0, a3_0, busy0, done0, pass0;
    logic       a1_1, a2_1, a3_1, busy1, done1, pass1;
    logic [3:0] err0, err1;
    logic [7:0] fail0, fail1;
    logic [2:0] vec0, vec1;

    // Cell under test modelled as a truth table indexed by {A1,A2,A3}
    assign zn0 = tt0[{a1_0, a2_0, a3_0}];
    assign zn1 = tt1[{a1_1, a2_1, a3_1}];

    cell3_vector_checker u_dut0 (
        .clk(clk), .rst(rst0), .start(start0), .ZN(zn0),
        .A1(a1_0), .A2(a2_0), .A3(a3_0),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_vec(fail0), .vec_idx(vec0)
    );

    cell3_vector_checker #(.SETTLE_CYCLES(1), .EXPECT_MASK(8'h01)) u_dut1 (
        .clk(clk), .rst(rst1), .start(start1), .ZN(zn1),
        .A1(a1_1), .A2(a2_1), .A3(a3_1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_vec(fail1), .vec_idx(vec1)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] o_pins(input int d);
        return (d == 0) ? {a1_0, a2_0, a3_0} : {a1_1, a2_1, a3_1};
    endfunction
    function automatic logic [2:0] o_vec(input int d);  return (d == 0) ? vec0  : vec1;  endfunction
    function automatic logic o_busy(input int d);        return (d == 0) ? busy0 : busy1; endfunction
    function automatic logic o_done(input int d);        return (d == 0) ? done0 : done1; endfunction
    function automatic logic o_pass(input int d);        return (d == 0) ? pass0 : pass1; endfunction
    function automatic logic [3:0] o_err(input int d);   return (d == 0) ? err0  : err1;  endfunction
    function automatic logic [7:0] o_fail(input int d);  return (d == 0) ? fail0 : fail1; endfunction

    task automatic drive(input int d, input logic st, input logic rs);
        if (d == 0) begin start0 = st; rst0 = rs; end
        else        begin start1 = st; rst1 = rs; end
    endtask

    task automatic check_cleared(input int d, input string tag);
        check({tag, ".pins"}, o_pins(d), 0);
        check({tag, ".vec"},  o_vec(d),  0);
        check({tag, ".busy"}, o_busy(d), 0);
        check({tag, ".done"}, o_done(d), 0);
        check({tag, ".pass"}, o_pass(d), 0);
        check({tag, ".err"},  o_err(d),  0);
        check({tag, ".fail"}, o_fail(d), 0);
    endtask

    // One sweep. restart_at/rst_at are edge numbers relative to E0 (0 = unused).
    task automatic run_sweep(input int d, input logic [7:0] tt, input int restart_at,
                             input int rst_at, input int gap);
        int         hold;
        int         total;
        logic [7:0] mask;
        logic [7:0] exp_fail;
        hold     = (d == 0) ? 3 : 2;
        total    = 8 * hold;
        mask     = (d == 0) ? 8'h7F : 8'h01;
        exp_fail = tt ^ mask;
        if (d == 0) tt0 = tt; else tt1 = tt;
        @(negedge clk);
        drive(d, 1'b1, 1'b0);
        @(negedge clk);
        drive(d, 1'b0, 1'b0);
        for (int k = 0; k < total; k++) begin
            check("sweep.vec",  o_vec(d),  k / hold);
            check("sweep.pins", o_pins(d), k / hold);
            check("sweep.busy", o_busy(d), 1);
            check("sweep.done", o_done(d), 0);
            drive(d, (k + 1 == restart_at), (k + 1 == rst_at));
            @(negedge clk);
            drive(d, 1'b0, 1'b0);
            if (k + 1 == rst_at) begin
                check_cleared(d, "midrst");
                return;
            end
        end
        check("end.done", o_done(d), 1);
        check("end.busy", o_busy(d), 0);
        check("end.err",  o_err(d),  $countones(exp_fail));
        check("end.fail", o_fail(d), exp_fail);
        check("end.pass", o_pass(d), exp_fail == 8'h00);
        check("end.pins", o_pins(d), 7);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check("hold.done", o_done(d), 1);
            check("hold.fail", o_fail(d), exp_fail);
            check("hold.pins", o_pins(d), 7);
        end
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
        tt0 = 8'h7F; tt1 = 8'h01;
        repeat (3) @(negedge clk);
        check_cleared(0, "reset0");
        check_cleared(1, "reset1");
        rst0 = 1'b0; rst1 = 1'b0;

        run_sweep(0, 8'h7F, 0, 0, 2);   // NAND3 cell
        run_sweep(0, 8'h80, 0, 0, 2);   // AND3 cell: every vector wrong
        run_sweep(0, 8'hFF, 0, 0, 2);   // ZN stuck at 1
        run_sweep(1, 8'h01, 0, 0, 2);   // NOR3 on the SETTLE=1 instance
        run_sweep(0, 8'h7F, 5, 0, 3);   // start re-pulse mid-sweep is ignored
        run_sweep(0, 8'h7F, 0, 0, 1);   // restart straight from DONE
        run_sweep(0, 8'h7F, 0, 10, 0);  // reset mid-sweep
        run_sweep(0, 8'h7F, 0, 0, 1);

        // rst and start together: rst wins
        @(negedge clk);
        drive(1, 1'b1, 1'b1);
        @(negedge clk);
        drive(1, 1'b0, 1'b0);
        check_cleared(1, "rststart");

        for (int r = 0; r < 8; r++) begin
            int         d;
            logic [7:0] tt;
            d  = int'($urandom_range(1, 0));
            tt = 8'($urandom);
            if ($urandom_range(3, 0) == 0) tt = (d == 0) ? 8'h7F : 8'h01;
            run_sweep(d, tt, int'($urandom_range(12, 0)), 0, int'($urandom_range(3, 0)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
